// File: rtl/rgb_to_ycbcr_pipe_pkg.sv
// Shared types and coefficient generation for the RGB -> YCbCr converter.
// RGB_YCBCR_LIMITED_RANGE_EN folds the studio-range scale into the coefficients.
package color_pkg;

  localparam int CSC_PIX_W = 8;

  typedef enum logic {
    CSC_BT601 = 1'b0,
    CSC_BT709 = 1'b1
  } csc_mode_t;

  typedef struct packed {
    logic [CSC_PIX_W-1:0] r;
    logic [CSC_PIX_W-1:0] g;
    logic [CSC_PIX_W-1:0] b;
  } rgb_pix_t;

  typedef struct packed {
    logic [CSC_PIX_W-1:0] y;
    logic [CSC_PIX_W-1:0] cb;
    logic [CSC_PIX_W-1:0] cr;
  } ycbcr_pix_t;

  typedef struct packed {
    int yr;  int yg;  int yb;
    int cbr; int cbg; int cbb;
    int crr; int crg; int crb;
  } coef_set_t;

  function automatic int quant(input real c, input int frac_w);
    real s;
    s = c * (2.0 ** frac_w);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction

  // The middle tap of each row absorbs quantisation error so row sums are exact.
  function automatic coef_set_t coef(input csc_mode_t mode, input int frac_w);
    real kr, kb, ys, cs;
    coef_set_t c;
    if (mode == CSC_BT709) begin
      kr = 0.2126;
      kb = 0.0722;
    end else begin
      kr = 0.299;
      kb = 0.114;
    end
`ifdef RGB_YCBCR_LIMITED_RANGE_EN
    ys = 219.0 / 255.0;
    cs = 224.0 / 255.0;
`else
    ys = 1.0;
    cs = 1.0;
`endif
    c.yr  = quant(kr * ys, frac_w);
    c.yb  = quant(kb * ys, frac_w);
    c.yg  = quant(ys, frac_w) - c.yr - c.yb;
    c.cbb = quant(0.5 * cs, frac_w);
    c.cbr = -quant(kr / (2.0 * (1.0 - kb)) * cs, frac_w);
    c.cbg = -c.cbb - c.cbr;
    c.crr = quant(0.5 * cs, frac_w);
    c.crb = -quant(kb / (2.0 * (1.0 - kr)) * cs, frac_w);
    c.crg = -c.crr - c.crb;
    return c;
  endfunction

endpackage

// File: rtl/rgb_to_ycbcr_pipe_if.sv
// Pixel-in / triple-out handshake bundle of the RGB -> YCbCr converter.
interface rgb_to_ycbcr_pipe_if #(
  parameter int PIX_W = 8
);
  logic             valid_in;
  logic             ready_out;
  logic [PIX_W-1:0] red_in;
  logic [PIX_W-1:0] green_in;
  logic [PIX_W-1:0] blue_in;
  logic             mode_in;
  logic             valid_out;
  logic             ready_in;
  logic [PIX_W-1:0] y_out;
  logic [PIX_W-1:0] cb_out;
  logic [PIX_W-1:0] cr_out;

  modport master (
    output valid_in, red_in, green_in, blue_in, mode_in, ready_in,
    input  ready_out, valid_out, y_out, cb_out, cr_out
  );

  modport slave (
    input  valid_in, red_in, green_in, blue_in, mode_in, ready_in,
    output ready_out, valid_out, y_out, cb_out, cr_out
  );
endinterface

// File: rtl/rgb_to_ycbcr_pipe_row.sv
// One 3-tap signed MAC row: product, sum and round/offset/clamp registers,
// all advancing together on i_en.
module csc_row_mac #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 16,
  parameter int CW     = PIX_W + FRAC_W + 2,
  parameter int OFFSET = 0,
  parameter int LO     = 0,
  parameter int HI     = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [PIX_W-1:0]     i_a,
  input  logic [PIX_W-1:0]     i_b,
  input  logic [PIX_W-1:0]     i_c,
  input  logic signed [CW-1:0] i_ka,
  input  logic signed [CW-1:0] i_kb,
  input  logic signed [CW-1:0] i_kc,
  output logic [PIX_W-1:0]     o_res
);
  localparam int PW = PIX_W + 1 + CW;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] L_HALF = SW'(1'b1) <<< (FRAC_W - 1);
  localparam logic signed [SW-1:0] L_OFF  = SW'(OFFSET);
  localparam logic signed [SW-1:0] L_LO   = SW'(LO);
  localparam logic signed [SW-1:0] L_HI   = SW'(HI);

  logic signed [PW-1:0] w_pa, w_pb, w_pc;
  logic signed [PW-1:0] r_pa, r_pb, r_pc;
  logic signed [SW-1:0] r_sum;
  logic signed [SW-1:0] w_off;
  logic [PIX_W-1:0]     w_clip;
  logic [PIX_W-1:0]     r_res;

  assign w_pa = PW'($signed({1'b0, i_a})) * PW'(i_ka);
  assign w_pb = PW'($signed({1'b0, i_b})) * PW'(i_kb);
  assign w_pc = PW'($signed({1'b0, i_c})) * PW'(i_kc);

  // Round to nearest with an arithmetic shift, then offset.
  assign w_off = ((r_sum + L_HALF) >>> FRAC_W) + L_OFF;

  // Saturate to the legal output range.
  always_comb begin
    w_clip = w_off[PIX_W-1:0];
    if (w_off < L_LO) begin
      w_clip = L_LO[PIX_W-1:0];
    end else if (w_off > L_HI) begin
      w_clip = L_HI[PIX_W-1:0];
    end else begin
      w_clip = w_off[PIX_W-1:0];
    end
  end

  // Three pipeline stages; all hold while the pipe is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pa  <= '0;
      r_pb  <= '0;
      r_pc  <= '0;
      r_sum <= '0;
      r_res <= '0;
    end else if (i_en) begin
      r_pa  <= w_pa;
      r_pb  <= w_pb;
      r_pc  <= w_pc;
      r_sum <= SW'(r_pa) + SW'(r_pb) + SW'(r_pc);
      r_res <= w_clip;
    end
  end

  assign o_res = r_res;
endmodule

// File: rtl/rgb_to_ycbcr_pipe.sv
// Three-stage RGB -> YCbCr converter with per-pixel BT.601/BT.709 selection.
// RGB_YCBCR_LIMITED_RANGE_EN selects studio-range output.
module rgb_to_ycbcr_pipe
  import color_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 16
) (
  input logic                clk_in,
  input logic                rst_n_in,
  rgb_to_ycbcr_pipe_if.slave bus
);
  localparam int CW = PIX_W + FRAC_W + 2;
  localparam coef_set_t C601 = coef(CSC_BT601, FRAC_W);
  localparam coef_set_t C709 = coef(CSC_BT709, FRAC_W);
  localparam int C_OFF = 32'sd1 << (PIX_W - 8'd1);
`ifdef RGB_YCBCR_LIMITED_RANGE_EN
  localparam int Y_OFF = 32'sd16 << (PIX_W - 8'd8);
  localparam int Y_LO  = 32'sd16 << (PIX_W - 8'd8);
  localparam int Y_HI  = 32'sd235 << (PIX_W - 8'd8);
  localparam int C_LO  = 32'sd16 << (PIX_W - 8'd8);
  localparam int C_HI  = 32'sd240 << (PIX_W - 8'd8);
`else
  localparam int Y_OFF = 32'sd0;
  localparam int Y_LO  = 32'sd0;
  localparam int Y_HI  = (32'sd1 << PIX_W) - 32'sd1;
  localparam int C_LO  = 32'sd0;
  localparam int C_HI  = (32'sd1 << PIX_W) - 32'sd1;
`endif

  logic w_stall, w_en, w_709;
  logic r_v1, r_v2, r_v3;
  logic signed [CW-1:0] w_kyr, w_kyg, w_kyb, w_kbr, w_kbg, w_kbb, w_krr, w_krg, w_krb;

  assign w_stall       = r_v3 && !bus.ready_in;
  assign w_en          = !w_stall;
  assign bus.ready_out = w_en;
  assign bus.valid_out = r_v3;

  // Mode picks the coefficient set as the pixel enters, so it travels with the pixel.
  assign w_709 = (csc_mode_t'(bus.mode_in) == CSC_BT709);
  assign w_kyr = w_709 ? CW'(C709.yr)  : CW'(C601.yr);
  assign w_kyg = w_709 ? CW'(C709.yg)  : CW'(C601.yg);
  assign w_kyb = w_709 ? CW'(C709.yb)  : CW'(C601.yb);
  assign w_kbr = w_709 ? CW'(C709.cbr) : CW'(C601.cbr);
  assign w_kbg = w_709 ? CW'(C709.cbg) : CW'(C601.cbg);
  assign w_kbb = w_709 ? CW'(C709.cbb) : CW'(C601.cbb);
  assign w_krr = w_709 ? CW'(C709.crr) : CW'(C601.crr);
  assign w_krg = w_709 ? CW'(C709.crg) : CW'(C601.crg);
  assign w_krb = w_709 ? CW'(C709.crb) : CW'(C601.crb);

  // Stage valid bits; bubbles travel as valid=0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= bus.valid_in;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  csc_row_mac #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CW(CW),
                .OFFSET(Y_OFF), .LO(Y_LO), .HI(Y_HI)) u_row_y (
    .i_clk(clk_in), .i_rst_n(rst_n_in), .i_en(w_en),
    .i_a(bus.red_in), .i_b(bus.green_in), .i_c(bus.blue_in),
    .i_ka(w_kyr), .i_kb(w_kyg), .i_kc(w_kyb), .o_res(bus.y_out)
  );

  csc_row_mac #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CW(CW),
                .OFFSET(C_OFF), .LO(C_LO), .HI(C_HI)) u_row_cb (
    .i_clk(clk_in), .i_rst_n(rst_n_in), .i_en(w_en),
    .i_a(bus.red_in), .i_b(bus.green_in), .i_c(bus.blue_in),
    .i_ka(w_kbr), .i_kb(w_kbg), .i_kc(w_kbb), .o_res(bus.cb_out)
  );

  csc_row_mac #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CW(CW),
                .OFFSET(C_OFF), .LO(C_LO), .HI(C_HI)) u_row_cr (
    .i_clk(clk_in), .i_rst_n(rst_n_in), .i_en(w_en),
    .i_a(bus.red_in), .i_b(bus.green_in), .i_c(bus.blue_in),
    .i_ka(w_krr), .i_kb(w_krg), .i_kc(w_krb), .o_res(bus.cr_out)
  );
endmodule

// File: doc/rgb_to_ycbcr_pipe.md
Name: rgb_to_ycbcr_pipe

Overview:
- Pipelined, parametrised colour-space converter: one RGB pixel per cycle in, one Y/Cb/Cr triple out.
- Runtime-selectable BT.601 / BT.709 coefficient sets, with rounding and saturation.
- Full valid/ready handshake on both sides.
- Sits between the camera pixel unpacker and the downstream luma/chroma consumers (thresholding, frame buffer writer); supersedes the luma-only converter.

Parameters:
- PIX_W, 8, bits per colour component in and out.
- FRAC_W, 16, fractional bits of the signed fixed-point coefficients.

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  input pixel valid
- ready_out  output  1  converter can accept a pixel this cycle
- red_in  input  PIX_W  red component
- green_in  input  PIX_W  green component
- blue_in  input  PIX_W  blue component
- mode_in  input  1  0 = BT.601, 1 = BT.709; sampled with each accepted pixel
- valid_out  output  1  output triple valid
- ready_in  input  1  downstream accepts the triple
- y_out  output  PIX_W  luma
- cb_out  output  PIX_W  blue-difference chroma, offset binary
- cr_out  output  PIX_W  red-difference chroma, offset binary

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset state: all stage valid bits 0, valid_out=0, y_out/cb_out/cr_out=0. ready_out=1 once reset deasserts.
- Reset asserted mid-operation drops in-flight pixels silently.
- Pipeline has 3 stages:
  - S1: register the nine products component*coef (coef signed, PIX_W+FRAC_W+2 bits), plus the pixel's mode.
  - S2: register the three row sums.
  - S3: rounding, offset and clamp; the registered results drive the outputs.
- Latency: exactly 3 cycles from acceptance to valid_out when ready_in stays high. Throughput: 1 pixel/cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - stall = valid_out && !ready_in. All stages hold while stall=1.
  - ready_out = !stall (combinational from ready_in).
  - Bubbles propagate as valid=0; no compaction.
  - While valid_out=1 and ready_in=0, outputs are stable.
- Arithmetic:
  - Coefficients = round(c * 2^FRAC_W).
  - The Y row sums to exactly 2^FRAC_W (the G coefficient absorbs the quantisation error). The Cb and Cr rows each sum to exactly 0.
  - Round to nearest: add 2^(FRAC_W-1) before the arithmetic shift right by FRAC_W.
  - Cb and Cr add 2^(PIX_W-1) after the shift.
  - Clamp the final result to [0, 2^PIX_W-1]: negative gives 0, overflow gives all-ones.
- Mode is latched per pixel. Changing mode_in between consecutive pixels produces each pixel in its own mode, with no flush required.

Optional Feature:
- Macro: RGB_YCBCR_LIMITED_RANGE_EN.
- Defined: the output is studio range.
  - Y is scaled by 219/255 and offset by 16<<(PIX_W-8); the clamp is [16, 235] scaled to PIX_W.
  - Cb and Cr are scaled by 224/255; the clamp is [16, 240] scaled.
  - The scale is folded into the coefficient constants, so latency is unchanged.
- Undefined: full range as above.

Decomposition:
- Package color_pkg holds:
  - Enum csc_mode_t (CSC_BT601, CSC_BT709).
  - Packed struct rgb_pix_t and ycbcr_pix_t, width set by PIX_W.
  - Function coef() returning the quantised coefficient set for (mode, FRAC_W), with full- and limited-range variants under the macro.
- Sub-module csc_row_mac: one 3-tap signed MAC row with pipeline registers, round, offset and clamp. It is instantiated three times (Y, Cb, Cr) and shares the stall enable.

Test Plan:
- Reset, then BT.601, RGB (255,255,255) -> 3 cycles later Y=255, Cb=128, Cr=128. RGB (0,0,0) -> Y=0, Cb=128, Cr=128.
- BT.601, RGB (255,0,0) -> Y=76, Cb=85, Cr=255 (saturated).
- BT.709, RGB (0,255,0) -> Y=182, Cb=30, Cr=12. Then alternate mode_in every pixel -> each output matches its own mode.
- Continuous stream of 64 random pixels with ready_in toggling pseudo-randomly -> outputs match the scoreboard model bit-exactly, with no drops or duplicates. Outputs hold stable while stalled, and ready_out=0 exactly when valid_out && !ready_in.
- Assert rst_n_in asynchronously (not on a clock edge) with 3 pixels in flight -> valid_out falls immediately and outputs are 0. After release, the first new pixel appears after 3 cycles.
- With RGB_YCBCR_LIMITED_RANGE_EN defined: white -> Y=235, Cb=128, Cr=128. Black -> Y=16, Cb=128, Cr=128.
